stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Parametrised multi-digit BCD stopwatch; the next generation of the team's single 4-bit stopwatch counter. It adds a clock prescaler, explicit run/hold/idle states, a synchronous clear, a sticky overflow flag and an optional lap-capture register. It sits between the push-button/debounce logic and the display driver, with one BCD nibble per display digit.

## Interface
- DIGITS, 4: number of BCD digits; count range 0 to 10^DIGITS-1.
- TICK_DIV, 1: clock cycles per count increment (≥1); prescaler width is clog2(TICK_DIV), minimum 1 bit.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  level-sampled; enter or resume RUN.
- stop  in  1  level-sampled; enter HOLD.
- clear  in  1  synchronous clear to IDLE.
- lap  in  1  capture current count (only with STOPWATCH_LAP_EN).
- cnt  out  4*DIGITS  BCD count; digit 0 (least significant) in bits [3:0].
- lap_cnt  out  4*DIGITS  last captured count.
- lap_valid  out  1  one-cycle pulse after a capture.
- running  out  1  high in RUN.
- ovf  out  1  sticky; set on wrap from all-9s to zero.

## Operation
- States: IDLE (count zero, stopped), RUN, HOLD (stopped, count retained).
- Transitions, evaluated on each edge in priority order clear > stop > start:
  - clear: any state → IDLE.
  - stop: RUN → HOLD. Ignored in IDLE and HOLD.
  - start: IDLE → RUN, HOLD → RUN. Ignored in RUN.
- start and stop together: stop wins. From IDLE the block stays in IDLE; from RUN it goes to HOLD.
- Prescaler `pre` counts 0..TICK_DIV-1 only in RUN.
  - tick = RUN && pre==TICK_DIV-1; on a tick `pre` returns to 0.
  - `pre` holds in HOLD and is zeroed in IDLE and by clear.
- Increment occurs on an edge where tick=1 and stop=0 and clear=0.
  - BCD ripple: digit i increments when all lower digits are 9. A digit at 9 rolls to 0.
  - At 10^DIGITS-1 the count wraps to all zeros and ovf is set.
- ovf stays high until clear or reset. Further wraps keep it at 1.
- clear zeros cnt, pre and ovf. It does not affect lap_cnt.
- Digits never hold values A–F. Invalid values are unreachable.

## Timing
- Reset values: cnt=0, lap_cnt=0, lap_valid=0, running=0, ovf=0, state IDLE, pre=0.
- running is registered. It rises the cycle after the edge that samples start, and falls the cycle after the edge that samples stop or clear.
- Start latency: start sampled at edge E0; first increment at edge E(TICK_DIV). With TICK_DIV=1, cnt=1 is visible after E1.
- Stop: an increment due on the stop edge is suppressed. cnt is frozen from that edge on.
- Resume from HOLD continues from the held `pre` value, so no partial period is lost.
- Reset asserted mid-count forces all reset values immediately, without waiting for a clock edge.

## Configuration
- STOPWATCH_LAP_EN defined:
  - lap sampled in RUN or HOLD copies the pre-edge cnt into lap_cnt.
  - lap_valid pulses high for exactly one cycle.
  - lap in IDLE is ignored.
  - lap with clear on the same edge captures the pre-clear value.
  - lap on an increment edge captures the pre-increment value.
- Undefined: lap is ignored, lap_cnt is tied to 0, lap_valid is tied to 0, and no lap register is built.

## Test plan
- DIGITS=4, TICK_DIV=1: reset, pulse start 1 cycle, run 12 cycles → cnt=0x0012 BCD, running=1.
- DIGITS=2, TICK_DIV=3: start, then 3*100 cycles → cnt wraps 99→00 and ovf=1. Then clear → cnt=0x00, ovf=0, state IDLE.
- TICK_DIV=4: start, stop after 6 cycles (pre=1), hold 10 cycles → cnt unchanged. Then start → next increment occurs 3 cycles later.
- Hold start and stop high together from IDLE, then from RUN → IDLE stays IDLE with running=0; RUN goes to HOLD with running=0 the next cycle.
- LAP_EN: at cnt=0x0047, pulse lap → lap_cnt=0x0047 and lap_valid high for 1 cycle while cnt keeps counting. Without LAP_EN → lap_cnt=0 and lap_valid=0 throughout.
- Drop rst low asynchronously mid-cycle while cnt=0x0375 in RUN → all outputs zero before the next edge; block resumes only on a new start.

Source files
------------

// File: rtl/stopwatch_bcd_if.sv
// Stopwatch control/status bundle: control levels from the button logic,
// BCD count and status toward the display driver. DIGITS must match the
// DIGITS of the stopwatch_bcd instance it connects to.
interface stopwatch_bcd_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  lap;
  logic [4*DIGITS-1:0]   cnt;
  logic [4*DIGITS-1:0]   lap_cnt;
  logic                  lap_valid;
  logic                  running;
  logic                  ovf;

  // Button/controller side.
  modport master (
    output start, stop, clear, lap,
    input  cnt, lap_cnt, lap_valid, running, ovf
  );

  // Stopwatch side.
  modport slave (
    input  start, stop, clear, lap,
    output cnt, lap_cnt, lap_valid, running, ovf
  );

endinterface

// File: rtl/stopwatch_bcd.sv
// Multi-digit BCD stopwatch with clock prescaler, IDLE/RUN/HOLD control,
// synchronous clear and sticky wrap flag. Define STOPWATCH_LAP_EN to build the
// lap-capture register; otherwise lap is ignored and the lap outputs read 0.
module stopwatch_bcd #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  stopwatch_bcd_if.slave sw_if
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntW = 4 * DIGITS;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [PreW-1:0]   r_pre;
  logic [PreW-1:0]   w_pre_d;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_d;
  logic [CntW-1:0]   w_cnt_inc;
  logic              r_ovf;
  logic              w_ovf_d;
  logic              w_wrap;
  logic              w_tick;
  logic              w_advance;

  // Prescaler only moves on RUN edges that are not overridden by stop/clear.
  assign w_tick    = (r_state == StRun) && (r_pre == PreMax);
  assign w_advance = (r_state == StRun) && !sw_if.stop && !sw_if.clear;

  // State, prescaler, count and overflow registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_pre   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pre   <= w_pre_d;
      r_cnt   <= w_cnt_d;
      r_ovf   <= w_ovf_d;
    end
  end

  // Next state, priority clear > stop > start.
  always_comb begin
    w_state_d = r_state;
    if (sw_if.clear) begin
      w_state_d = StIdle;
    end else if (sw_if.stop) begin
      if (r_state == StRun) w_state_d = StHold;
    end else if (sw_if.start && (r_state != StRun)) begin
      w_state_d = StRun;
    end
  end

  // BCD ripple increment: a digit advances only when every lower digit is 9.
  always_comb begin
    logic w_carry;
    w_carry   = 1'b1;
    w_cnt_inc = r_cnt;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_cnt[4*i +: 4] == 4'd9) begin
          w_cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          w_cnt_inc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
    // Carry out of the top digit means the count was all 9s.
    w_wrap = w_carry;
  end

  // Prescaler, count and overflow next values.
  always_comb begin
    w_pre_d = r_pre;
    w_cnt_d = r_cnt;
    w_ovf_d = r_ovf;
    if (sw_if.clear) begin
      w_pre_d = '0;
      w_cnt_d = '0;
      w_ovf_d = 1'b0;
    end else if (w_advance) begin
      if (w_tick) begin
        w_pre_d = '0;
        w_cnt_d = w_cnt_inc;
        if (w_wrap) w_ovf_d = 1'b1;
      end else begin
        w_pre_d = r_pre + PreW'(1);
      end
    end
  end

  assign sw_if.cnt     = r_cnt;
  assign sw_if.ovf     = r_ovf;
  // Decoded straight from the state register, so it is glitch-free.
  assign sw_if.running = (r_state == StRun);

`ifdef STOPWATCH_LAP_EN
  logic [CntW-1:0] r_lap_cnt;
  logic            r_lap_valid;
  logic            w_lap_cap;

  assign w_lap_cap = sw_if.lap && (r_state != StIdle);

  // Lap capture of the pre-edge count; unaffected by clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lap_cnt   <= '0;
      r_lap_valid <= 1'b0;
    end else begin
      r_lap_valid <= w_lap_cap;
      if (w_lap_cap) r_lap_cnt <= r_cnt;
    end
  end

  assign sw_if.lap_cnt   = r_lap_cnt;
  assign sw_if.lap_valid = r_lap_valid;
`else
  logic w_unused_lap;
  assign w_unused_lap    = sw_if.lap;
  assign sw_if.lap_cnt   = '0;
  assign sw_if.lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: three instances (4/1, 2/3, 3/4 digits/divider)
// share one stimulus stream and are compared every cycle against an
// integer-count model; directed sequences add literal expectations.
module tb_stopwatch_bcd;

`ifdef STOPWATCH_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  localparam int TD  [3] = '{1, 3, 4};
  localparam int MOD [3] = '{10000, 100, 1000};
  localparam int DG  [3] = '{4, 2, 3};

  logic clk = 1'b0;
  logic rst_n;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_bcd_if #(.DIGITS(4)) if_a ();
  stopwatch_bcd_if #(.DIGITS(2)) if_b ();
  stopwatch_bcd_if #(.DIGITS(3)) if_c ();

  assign if_a.start = start;  assign if_a.stop = stop;
  assign if_a.clear = clear;  assign if_a.lap  = lap;
  assign if_b.start = start;  assign if_b.stop = stop;
  assign if_b.clear = clear;  assign if_b.lap  = lap;
  assign if_c.start = start;  assign if_c.stop = stop;
  assign if_c.clear = clear;  assign if_c.lap  = lap;

  stopwatch_bcd #(.DIGITS(4), .TICK_DIV(1)) u_dut_a (.i_clk(clk), .i_rst_n(rst_n), .sw_if(if_a));
  stopwatch_bcd #(.DIGITS(2), .TICK_DIV(3)) u_dut_b (.i_clk(clk), .i_rst_n(rst_n), .sw_if(if_b));
  stopwatch_bcd #(.DIGITS(3), .TICK_DIV(4)) u_dut_c (.i_clk(clk), .i_rst_n(rst_n), .sw_if(if_c));

  logic [15:0] d_cnt [3];
  logic [15:0] d_lap [3];
  logic        d_lv  [3];
  logic        d_run [3];
  logic        d_ovf [3];

  assign d_cnt[0] = if_a.cnt;           assign d_cnt[1] = {8'h00, if_b.cnt};
  assign d_cnt[2] = {4'h0, if_c.cnt};
  assign d_lap[0] = if_a.lap_cnt;       assign d_lap[1] = {8'h00, if_b.lap_cnt};
  assign d_lap[2] = {4'h0, if_c.lap_cnt};
  assign d_lv[0]  = if_a.lap_valid;     assign d_lv[1]  = if_b.lap_valid;
  assign d_lv[2]  = if_c.lap_valid;
  assign d_run[0] = if_a.running;       assign d_run[1] = if_b.running;
  assign d_run[2] = if_c.running;
  assign d_ovf[0] = if_a.ovf;           assign d_ovf[1] = if_b.ovf;
  assign d_ovf[2] = if_c.ovf;

  // Model: 0 = idle, 1 = run, 2 = hold; count kept as a plain integer.
  int m_state [3] = '{0, 0, 0};
  int m_pre   [3] = '{0, 0, 0};
  int m_count [3] = '{0, 0, 0};
  int m_lap   [3] = '{0, 0, 0};
  bit m_lv    [3] = '{0, 0, 0};
  bit m_ovf   [3] = '{0, 0, 0};

  function automatic logic [15:0] to_bcd(input int v, input int d);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_state[i] = 0; m_pre[i] = 0; m_count[i] = 0;
        m_lap[i] = 0;   m_lv[i] = 1'b0; m_ovf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit tick;
        tick = (m_state[i] == 1) && (m_pre[i] == TD[i] - 1);
        m_lv[i] = LapEn && lap && (m_state[i] != 0);
        if (m_lv[i]) m_lap[i] = m_count[i];
        if (clear) begin
          m_state[i] = 0; m_pre[i] = 0; m_count[i] = 0; m_ovf[i] = 1'b0;
        end else if (stop) begin
          if (m_state[i] == 1) m_state[i] = 2;
        end else if (start && m_state[i] != 1) begin
          m_state[i] = 1;
        end else if (m_state[i] == 1) begin
          if (tick) begin
            m_pre[i]   = 0;
            m_count[i] = (m_count[i] + 1) % MOD[i];
            if (m_count[i] == 0) m_ovf[i] = 1'b1;
          end else begin
            m_pre[i]++;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cnt[%0d]", i), d_cnt[i], to_bcd(m_count[i], DG[i]));
      chk($sformatf("lap_cnt[%0d]", i), d_lap[i], to_bcd(m_lap[i], DG[i]));
      chk($sformatf("lap_valid[%0d]", i), {15'd0, d_lv[i]}, {15'd0, m_lv[i]});
      chk($sformatf("running[%0d]", i), {15'd0, d_run[i]}, {15'd0, m_state[i] == 1});
      chk($sformatf("ovf[%0d]", i), {15'd0, d_ovf[i]}, {15'd0, m_ovf[i]});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    chk("reset cnt", d_cnt[0], 16'h0000);
    chk("reset running", {15'd0, d_run[0]}, 16'h0000);
    chk("reset ovf", {15'd0, d_ovf[0]}, 16'h0000);
    chk("reset lap_valid", {15'd0, d_lv[0]}, 16'h0000);

    // Start then 12 cycles.
    pulse_start();
    repeat (12) step();
    chk("run12 cnt a", d_cnt[0], 16'h0012);
    chk("run12 running a", {15'd0, d_run[0]}, 16'h0001);
    chk("run12 cnt b", d_cnt[1], 16'h0004);
    chk("run12 cnt c", d_cnt[2], 16'h0003);

    // 300 cycles: two-digit /3 wraps 99 -> 00.
    pulse_clear();
    pulse_start();
    repeat (300) step();
    chk("wrap cnt b", d_cnt[1], 16'h0000);
    chk("wrap ovf b", {15'd0, d_ovf[1]}, 16'h0001);
    chk("wrap cnt a", d_cnt[0], 16'h0300);
    chk("wrap ovf a", {15'd0, d_ovf[0]}, 16'h0000);
    chk("wrap cnt c", d_cnt[2], 16'h0075);
    pulse_clear();
    chk("clear cnt b", d_cnt[1], 16'h0000);
    chk("clear ovf b", {15'd0, d_ovf[1]}, 16'h0000);
    chk("clear running b", {15'd0, d_run[1]}, 16'h0000);

    // Divider 4: stop with pre=1, hold, resume after 3 more edges.
    pulse_start();
    repeat (5) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop cnt c", d_cnt[2], 16'h0001);
    chk("stop running c", {15'd0, d_run[2]}, 16'h0000);
    repeat (10) step();
    chk("hold cnt c", d_cnt[2], 16'h0001);
    pulse_start();
    step(); step();
    chk("resume+2 cnt c", d_cnt[2], 16'h0001);
    step();
    chk("resume+3 cnt c", d_cnt[2], 16'h0002);

    // start and stop together.
    pulse_clear();
    start = 1'b1; stop = 1'b1;
    repeat (3) step();
    chk("both idle running", {15'd0, d_run[0]}, 16'h0000);
    chk("both idle cnt", d_cnt[0], 16'h0000);
    stop = 1'b0; step();
    chk("run running", {15'd0, d_run[0]}, 16'h0001);
    stop = 1'b1; step();
    start = 1'b0; stop = 1'b0;
    chk("both run running", {15'd0, d_run[0]}, 16'h0000);
    repeat (3) step();
    chk("both run cnt", d_cnt[0], 16'h0000);

    // Lap at 47.
    pulse_clear();
    pulse_start();
    repeat (47) step();
    chk("pre-lap cnt", d_cnt[0], 16'h0047);
    lap = 1'b1; step(); lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
    chk("lap cnt", d_lap[0], 16'h0047);
    chk("lap valid", {15'd0, d_lv[0]}, 16'h0001);
    chk("lap keeps counting", d_cnt[0], 16'h0048);
    step();
    chk("lap valid drop", {15'd0, d_lv[0]}, 16'h0000);
    chk("lap cnt held", d_lap[0], 16'h0047);
`else
    chk("lap cnt off", d_lap[0], 16'h0000);
    chk("lap valid off", {15'd0, d_lv[0]}, 16'h0000);
    chk("lap keeps counting", d_cnt[0], 16'h0048);
`endif

    // Async reset mid-cycle at 375.
    pulse_clear();
    pulse_start();
    repeat (375) step();
    chk("pre-rst cnt", d_cnt[0], 16'h0375);
    #1 rst_n = 1'b0;
    #1;
    chk("async cnt a", d_cnt[0], 16'h0000);
    chk("async running a", {15'd0, d_run[0]}, 16'h0000);
    chk("async cnt c", d_cnt[2], 16'h0000);
    chk("async lap a", d_lap[0], 16'h0000);
    #8 rst_n = 1'b1;
    repeat (4) step();
    chk("post-rst cnt", d_cnt[0], 16'h0000);
    chk("post-rst running", {15'd0, d_run[0]}, 16'h0000);
    pulse_start();
    repeat (5) step();
    chk("restart cnt", d_cnt[0], 16'h0005);

    // Random control traffic.
    repeat (3000) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 14) == 0);
      clear = ($urandom_range(0, 59) == 0);
      lap   = ($urandom_range(0, 7) == 0);
      step();
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
